// File: rtl/clock_time_pkg.sv
// Shared constants and types for the BCD time-of-day keeper.
// Field limits are held as packed BCD bytes: high nibble tens, low nibble units.
package clock_time_pkg;

  localparam int UNITS_W   = 4;
  localparam int HR_TENS_W = 2;
  localparam int MS_TENS_W = 3;

  localparam logic [7:0] SEC_MAX     = 8'h59;
  localparam logic [7:0] MIN_MAX     = 8'h59;
  localparam logic [7:0] HOUR_MAX_24 = 8'h23;
  localparam logic [7:0] HOUR_MAX_12 = 8'h12;
  localparam logic [7:0] HOUR_MIN_12 = 8'h01;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_pair_t;

  function automatic int bcd_tens(
    input logic [7:0] b
  );
    return int'(b[7:4]);
  endfunction

  function automatic int bcd_units(
    input logic [7:0] b
  );
    return int'(b[3:0]);
  endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter with a configurable terminal value and wrap value.
// Reset and clear both load the wrap value; carry pulses as inc wraps the pair.
module bcd_pair_counter
  import clock_time_pkg::*;
#(
  parameter int TENS_W     = MS_TENS_W,
  parameter int MAX_TENS   = 5,
  parameter int MAX_UNITS  = 9,
  parameter int WRAP_TENS  = 0,
  parameter int WRAP_UNITS = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               clr,
  output logic [TENS_W-1:0]  tens,
  output logic [UNITS_W-1:0] units,
  output logic               carry
);

  localparam bcd_pair_t TOP = '{
    tens:  4'(MAX_TENS),
    units: 4'(MAX_UNITS)
  };
  localparam bcd_pair_t BOT = '{
    tens:  4'(WRAP_TENS),
    units: 4'(WRAP_UNITS)
  };

  localparam logic [TENS_W-1:0] TOP_T =
    TOP.tens[TENS_W-1:0];
  localparam logic [TENS_W-1:0] BOT_T =
    BOT.tens[TENS_W-1:0];
  localparam logic [UNITS_W-1:0] U_NINE =
    UNITS_W'(9);

  logic [TENS_W-1:0]  r_tens;
  logic [UNITS_W-1:0] r_units;

  logic w_at_top;
  logic w_u_wrap;

  assign w_at_top = (r_tens == TOP_T) &&
                    (r_units == TOP.units);

  // Units roll into tens only below the terminal value.
  assign w_u_wrap = (r_units == U_NINE) &&
                    !w_at_top;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tens  <= BOT_T;
      r_units <= BOT.units;
    end else if (clr) begin
      r_tens  <= BOT_T;
      r_units <= BOT.units;
    end else if (inc) begin
      unique case (1'b1)
        w_at_top: begin
          r_tens  <= BOT_T;
          r_units <= BOT.units;
        end
        w_u_wrap: begin
          r_tens  <= r_tens + TENS_W'(1);
          r_units <= '0;
        end
        default: begin
          r_units <= r_units + UNITS_W'(1);
        end
      endcase
    end
  end

  assign tens  = r_tens;
  assign units = r_units;
  assign carry = inc && !clr && w_at_top;

endmodule

// File: rtl/clock_time_keeper.sv
// HH:MM:SS BCD time keeper driven by a prescaled 1 Hz tick.
// Debounced adjust pulses are edge-detected and merged with the carry chain.
module clock_time_keeper
  import clock_time_pkg::*;
#(
  parameter int CLK_HZ   = 25_000_000,
  parameter int HOURS_24 = 1
) (
  input  logic                 regular_clk,
  input  logic                 rst_n,
  input  logic                 adj_hours,
  input  logic                 adj_minutes,
  input  logic                 adj_seconds,
  output logic                 second_tick,
  output logic [HR_TENS_W-1:0] hours_tens,
  output logic [UNITS_W-1:0]   hours_units,
  output logic [MS_TENS_W-1:0] min_tens,
  output logic [UNITS_W-1:0]   min_units,
  output logic [MS_TENS_W-1:0] sec_tens,
  output logic [UNITS_W-1:0]   sec_units
);

  localparam int PSC_W =
    (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PSC_W-1:0] PSC_TOP =
    PSC_W'(CLK_HZ - 1);

  localparam logic [7:0] HR_TOP =
    (HOURS_24 != 0) ? HOUR_MAX_24 : HOUR_MAX_12;
  localparam logic [7:0] HR_BOT =
    (HOURS_24 != 0) ? 8'h00 : HOUR_MIN_12;

  logic [PSC_W-1:0] r_psc;
  logic             r_tick;
  logic             r_arm;
  logic [2:0]       r_adj_q;

  logic [2:0] w_adj;
  logic [2:0] w_edge;
  logic       w_wrap;
  logic       w_sec_inc;
  logic       w_sec_clr;
  logic       w_sec_carry;
  logic       w_min_inc;
  logic       w_min_carry;
  logic       w_hr_inc;
  logic       w_hr_carry_unused;

  assign w_adj = {adj_hours, adj_minutes, adj_seconds};

  // r_arm masks the first sampled level so a held button across reset is ignored.
  assign w_edge = w_adj & ~r_adj_q & {3{r_arm}};
  assign w_wrap = (r_psc == PSC_TOP);

  assign w_sec_clr = w_edge[0];
  assign w_sec_inc = w_wrap && !w_sec_clr;

  always_ff @(posedge regular_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc   <= '0;
      r_tick  <= 1'b0;
      r_arm   <= 1'b0;
      r_adj_q <= '0;
    end else begin
      r_arm   <= 1'b1;
      r_adj_q <= w_adj;
      r_tick  <= w_sec_inc;
      if (w_wrap || w_sec_clr) begin
        r_psc <= '0;
      end else begin
        r_psc <= r_psc + PSC_W'(1);
      end
    end
  end

  bcd_pair_counter #(
    .TENS_W     (MS_TENS_W),
    .MAX_TENS   (bcd_tens(SEC_MAX)),
    .MAX_UNITS  (bcd_units(SEC_MAX)),
    .WRAP_TENS  (0),
    .WRAP_UNITS (0)
  ) u_sec (
    .clk   (regular_clk),
    .rst_n (rst_n),
    .inc   (w_sec_inc),
    .clr   (w_sec_clr),
    .tens  (sec_tens),
    .units (sec_units),
    .carry (w_sec_carry)
  );

  // An adjust and a carry landing together still step the field only once.
  assign w_min_inc = w_sec_carry || w_edge[1];

  bcd_pair_counter #(
    .TENS_W     (MS_TENS_W),
    .MAX_TENS   (bcd_tens(MIN_MAX)),
    .MAX_UNITS  (bcd_units(MIN_MAX)),
    .WRAP_TENS  (0),
    .WRAP_UNITS (0)
  ) u_min (
    .clk   (regular_clk),
    .rst_n (rst_n),
    .inc   (w_min_inc),
    .clr   (1'b0),
    .tens  (min_tens),
    .units (min_units),
    .carry (w_min_carry)
  );

  // Only a wrap caused by the seconds carry may ripple into hours.
  assign w_hr_inc = (w_sec_carry && w_min_carry) ||
                    w_edge[2];

  bcd_pair_counter #(
    .TENS_W     (HR_TENS_W),
    .MAX_TENS   (bcd_tens(HR_TOP)),
    .MAX_UNITS  (bcd_units(HR_TOP)),
    .WRAP_TENS  (bcd_tens(HR_BOT)),
    .WRAP_UNITS (bcd_units(HR_BOT))
  ) u_hr (
    .clk   (regular_clk),
    .rst_n (rst_n),
    .inc   (w_hr_inc),
    .clr   (1'b0),
    .tens  (hours_tens),
    .units (hours_units),
    .carry (w_hr_carry_unused)
  );

  assign second_tick = r_tick;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Bench for clock_time_keeper: 24-hour and 12-hour instances share stimulus.
// A seconds-of-day style model is compared every cycle, plus literal checkpoints.
module tb_clock_time_keeper;

  localparam int HZ = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] adj = '0;
  bit         done = 1'b0;

  int checks = 0;
  int errors = 0;

  logic       tick_a, tick_b;
  logic [1:0] ht_a, ht_b;
  logic [3:0] hu_a, hu_b;
  logic [2:0] mt_a, mt_b;
  logic [3:0] mu_a, mu_b;
  logic [2:0] st_a, st_b;
  logic [3:0] su_a, su_b;

  always #5 clk = ~clk;

  clock_time_keeper #(
    .CLK_HZ   (HZ),
    .HOURS_24 (1)
  ) dut_a (
    .regular_clk (clk),
    .rst_n       (rst_n),
    .adj_hours   (adj[2]),
    .adj_minutes (adj[1]),
    .adj_seconds (adj[0]),
    .second_tick (tick_a),
    .hours_tens  (ht_a),
    .hours_units (hu_a),
    .min_tens    (mt_a),
    .min_units   (mu_a),
    .sec_tens    (st_a),
    .sec_units   (su_a)
  );

  clock_time_keeper #(
    .CLK_HZ   (HZ),
    .HOURS_24 (0)
  ) dut_b (
    .regular_clk (clk),
    .rst_n       (rst_n),
    .adj_hours   (adj[2]),
    .adj_minutes (adj[1]),
    .adj_seconds (adj[0]),
    .second_tick (tick_b),
    .hours_tens  (ht_b),
    .hours_units (hu_b),
    .min_tens    (mt_b),
    .min_units   (mu_b),
    .sec_tens    (st_b),
    .sec_units   (su_b)
  );

  // Behavioural model: plain integer time fields and a cycle counter.
  int m_psc = 0;
  int m_s = 0;
  int m_m = 0;
  int m_h24 = 0;
  int m_h12 = 1;
  bit m_tick = 0;
  bit m_arm = 0;
  bit [2:0] m_prev = '0;

  always @(posedge clk or negedge rst_n) begin
    bit eh, em, es, wrap, cs, cm;
    if (!rst_n) begin
      m_psc = 0; m_s = 0; m_m = 0;
      m_h24 = 0; m_h12 = 1;
      m_tick = 0; m_arm = 0; m_prev = '0;
    end else begin
      eh = m_arm && adj[2] && !m_prev[2];
      em = m_arm && adj[1] && !m_prev[1];
      es = m_arm && adj[0] && !m_prev[0];
      wrap = (m_psc == HZ - 1);
      m_tick = wrap && !es;
      cs = 0;
      cm = 0;
      if (es) begin
        m_s = 0;
        m_psc = 0;
      end else begin
        m_psc = wrap ? 0 : m_psc + 1;
        if (wrap) begin
          if (m_s == 59) begin
            m_s = 0;
            cs = 1;
          end else begin
            m_s = m_s + 1;
          end
        end
      end
      if (cs || em) begin
        cm = cs && (m_m == 59);
        m_m = (m_m + 1) % 60;
      end
      if (cm || eh) begin
        m_h24 = (m_h24 + 1) % 24;
        m_h12 = (m_h12 == 12) ? 1 : m_h12 + 1;
      end
      m_prev = adj;
      m_arm = 1;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d @%0t", nm, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        chk("tick_a", int'(tick_a), int'(m_tick));
        chk("hT_a", int'(ht_a), m_h24 / 10);
        chk("hU_a", int'(hu_a), m_h24 % 10);
        chk("mT_a", int'(mt_a), m_m / 10);
        chk("mU_a", int'(mu_a), m_m % 10);
        chk("sT_a", int'(st_a), m_s / 10);
        chk("sU_a", int'(su_a), m_s % 10);
        chk("tick_b", int'(tick_b), int'(m_tick));
        chk("hT_b", int'(ht_b), m_h12 / 10);
        chk("hU_b", int'(hu_b), m_h12 % 10);
        chk("mT_b", int'(mt_b), m_m / 10);
        chk("mU_b", int'(mu_b), m_m % 10);
        chk("sT_b", int'(st_b), m_s / 10);
        chk("sU_b", int'(su_b), m_s % 10);
      end
    end
  end

  function automatic int hr_a();
    return int'(ht_a) * 10 + int'(hu_a);
  endfunction

  function automatic int hr_b();
    return int'(ht_b) * 10 + int'(hu_b);
  endfunction

  function automatic int mn_a();
    return int'(mt_a) * 10 + int'(mu_a);
  endfunction

  function automatic int sc_a();
    return int'(st_a) * 10 + int'(su_a);
  endfunction

  task automatic lit(input string nm, input int h, input int m, input int s);
    chk({nm, "_hh"}, hr_a(), h);
    chk({nm, "_mm"}, mn_a(), m);
    chk({nm, "_ss"}, sc_a(), s);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int idx, input int n);
    repeat (n) begin
      @(negedge clk);
      adj[idx] = 1'b1;
      @(negedge clk);
      adj[idx] = 1'b0;
    end
  endtask

  task automatic wait_at(input int s, input int psc, input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (m_s == s && m_psc == psc) begin
        ok = 1;
        break;
      end
    end
    chk(nm, int'(ok), 1);
  endtask

  initial begin
    int nt, t1, t2, gap;

    cyc(2);
    rst_n = 1'b1;
    lit("reset", 0, 0, 0);
    chk("reset_tick", int'(tick_a), 0);
    chk("reset_h12", hr_b(), 1);

    cyc(35);
    #3 rst_n = 1'b0;
    #1;
    lit("async_rst", 0, 0, 0);
    chk("async_rst_tick", int'(tick_a), 0);
    @(negedge clk);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    pulse(2, 23);
    pulse(1, 59);
    wait_at(58, 0, "wait_58");
    lit("preload", 23, 59, 58);
    chk("preload_h12", hr_b(), 12);

    nt = 0;
    t1 = -1;
    t2 = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (tick_a) begin
        nt++;
        if (t1 < 0) t1 = i;
        else t2 = i;
      end
    end
    chk("roll_tick_count", nt, 2);
    chk("roll_tick_gap", t2 - t1, 10);
    lit("rollover", 0, 0, 0);
    chk("rollover_h12", hr_b(), 1);

    pulse(1, 59);
    chk("pre_hold_mm", mn_a(), 59);
    @(negedge clk);
    adj[1] = 1'b1;
    cyc(50);
    adj[1] = 1'b0;
    chk("hold_mm", mn_a(), 0);
    chk("hold_hh", hr_a(), 0);

    pulse(1, 5);
    wait_at(59, HZ - 1, "wait_559");
    adj[1] = 1'b1;
    @(negedge clk);
    adj[1] = 1'b0;
    lit("carry_coll", 0, 6, 0);

    pulse(1, 54);
    wait_at(41, HZ - 1, "wait_41");
    adj[0] = 1'b1;
    @(negedge clk);
    chk("clr_ss", sc_a(), 0);
    chk("clr_tick", int'(tick_a), 0);
    chk("clr_mm", mn_a(), 0);
    gap = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (tick_a) begin
        gap = i;
        break;
      end
    end
    adj[0] = 1'b0;
    chk("clr_next_tick", gap, 10);

    rst_n = 1'b0;
    adj[2] = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    adj[2] = 1'b0;
    chk("held_rst_h24", hr_a(), 0);
    chk("held_rst_h12", hr_b(), 1);

    pulse(2, 11);
    chk("h12_eleven", hr_b(), 12);
    chk("h24_eleven", hr_a(), 11);
    pulse(2, 1);
    chk("h12_wrap", hr_b(), 1);
    chk("h24_twelve", hr_a(), 12);

    cyc(2);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
